// File: rtl/core_mem_pkg.sv
// Shared definitions for the multicycle core's memory responder:
// FSM encoding and word-alignment constants.
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int         WORD_BYTES    = 4;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word memory: synchronous write, registered read, no reset.
module mem_word_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data memory responder with programmable wait states
// and error reporting for misaligned or out-of-range accesses.
module multicycle_mem_responder
  import core_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  function automatic logic addr_err(input logic [31:0] a);
    logic [31:0] word_idx;
    word_idx = {2'b00, a[31:2]};
    return ((a[1:0] & MISALIGN_MASK) != 2'b00) || (word_idx >= DEPTH_WORDS);
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q, rd_q;
  logic        accept, access;
  logic        acc_we, acc_err;
  logic [31:0] acc_addr, acc_wdata;
  logic [31:0] mem_rdata;

  assign accept = rst && (state == IDLE) && req_valid;

  // With zero wait states the access happens on the accepting edge itself,
  // so the live request is used until the captured copy exists.
  assign acc_we    = (state == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign acc_err   = addr_err(acc_addr);
  assign access    = rst && (state_nxt == RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        cnt_nxt   = LAT4;
        state_nxt = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (access) begin
      err_q <= acc_err;
      rd_q  <= !acc_we && !acc_err;
    end
  end

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk   (clk),
    .en    (access),
    .we    (acc_we && !acc_err),
    .idx   (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  assign req_ready  = (state == IDLE) && rst;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && rd_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Scoreboard bench: four responders with different wait-state counts,
// directed requests with hand-computed responses.
module tb_multicycle_mem_responder;

  function automatic int lat_of(input int i);
    case (i)
      0: return 0;
      1: return 2;
      2: return 3;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic [3:0]  rst, req_valid, req_we, req_ready, resp_valid, resp_err;
  logic [31:0] req_addr [4];
  logic [31:0] req_wdata [4];
  logic [31:0] resp_rdata [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    multicycle_mem_responder #(.DEPTH_WORDS(256), .LATENCY(lat_of(gi))) u_dut (
      .clk        (clk),
      .rst        (rst[gi]),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_we     (req_we[gi]),
      .req_addr   (req_addr[gi]),
      .req_wdata  (req_wdata[gi]),
      .resp_valid (resp_valid[gi]),
      .resp_rdata (resp_rdata[gi]),
      .resp_err   (resp_err[gi])
    );
  end

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (resp_valid[i] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp inst %0d: got resp_valid=1 expected none", i);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_inst", i, mon_e.inst);
          chk("resp_rdata", resp_rdata[i], mon_e.rdata);
          chk("resp_err", {31'b0, resp_err[i]}, {31'b0, mon_e.err});
          chk("resp_latency", cyc - mon_e.acc, lat_of(i) + 1);
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic issue(input int i, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    req_we[i] = we;
    req_addr[i] = a;
    req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    while (!req_ready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      chk("accept_timeout", {31'b0, req_ready[i]}, 32'd1);
      req_valid[i] = 1'b0;
      return;
    end
    e.inst = i; e.rdata = exp_rd; e.err = exp_err; e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid[i] = 1'b0;
    req_addr[i] = 32'hFFFF_FFFF;
    req_wdata[i] = 32'h0;
    wait_drain();
  endtask

  initial begin
    exp_t e;
    int   accepts, last_acc;
    rst = 4'b0000;
    req_valid = '0;
    req_we = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = '0;
      req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_ready", {31'b0, req_ready[i]}, 32'd0);
      chk("reset_valid", {31'b0, resp_valid[i]}, 32'd0);
      chk("reset_rdata", resp_rdata[i], 32'd0);
      chk("reset_err", {31'b0, resp_err[i]}, 32'd0);
    end
    rst = 4'b1111;

    // LATENCY=2: write/read, misaligned write, range boundary
    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1, 1'b1, 32'h13, 32'h12345678, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h410, 32'h0, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0);
    issue(1, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);

    // LATENCY=0: back-to-back reads with req_valid held high
    issue(0, 1'b1, 32'h10, 32'h0BADC0DE, 32'h0, 1'b0);
    @(negedge clk);
    req_we[0] = 1'b0;
    req_addr[0] = 32'h10;
    req_valid[0] = 1'b1;
    accepts = 0;
    last_acc = -1;
    for (int k = 0; k < 10; k++) begin
      if (resp_valid[0]) chk("ready_in_resp", {31'b0, req_ready[0]}, 32'd0);
      if (req_ready[0]) begin
        if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 32'd2);
        last_acc = cyc;
        accepts++;
        e.inst = 0; e.rdata = 32'h0BADC0DE; e.err = 1'b0; e.acc = cyc;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    chk("b2b_accepts", accepts, 32'd5);
    wait_drain();

    // LATENCY=3: reset aborts a pending write
    issue(2, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    req_we[2] = 1'b1;
    req_addr[2] = 32'h20;
    req_wdata[2] = 32'hA5A5A5A5;
    req_valid[2] = 1'b1;
    chk("abort_ready_before", {31'b0, req_ready[2]}, 32'd1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ready_in_reset", {31'b0, req_ready[2]}, 32'd0);
      chk("valid_in_reset", {31'b0, resp_valid[2]}, 32'd0);
    end
    rst[2] = 1'b1;
    repeat (6) @(negedge clk);
    issue(2, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
    issue(2, 1'b1, 32'h20, 32'h22222222, 32'h0, 1'b0);
    issue(2, 1'b0, 32'h20, 32'h0, 32'h22222222, 1'b0);

    // LATENCY=15: counter boundary
    issue(3, 1'b1, 32'h40, 32'h0F0F0F0F, 32'h0, 1'b0);
    issue(3, 1'b0, 32'h40, 32'h0, 32'h0F0F0F0F, 1'b0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_mem_responder.md
Name: multicycle_mem_responder

Overview:
- Memory-side responder for the multicycle RISC-V core: a unified instruction/data word memory with a valid/ready request channel and a single-cycle response pulse.
- Models a slow memory with a programmable number of wait states.
- Sits between the core's address/write-data path (AdrSrc mux, MemWrite) and its instruction and data registers.
- Reports misaligned and out-of-range accesses instead of silently aliasing them.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..65536.
- LATENCY, 2, wait states between request acceptance and response; 0..15.
- AW, clog2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  read data; valid only while resp_valid=1.
- resp_err  out  1  access error; valid only while resp_valid=1.

Behaviour:
- Reset: rst sampled low at a clk edge gives state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0 and cnt=0. req_ready is forced to 0 while rst=0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) & rst. It is combinational and has no dependence on req_valid.
- Accept: at an edge with state=IDLE and req_valid=1, capture req_we, req_addr and req_wdata. Set cnt=LATENCY.
  - If LATENCY==0, go to RESP.
  - Otherwise go to WAIT.
- WAIT: cnt decrements by 1 each edge. At the edge where cnt==1, go to RESP.
- The RESP entry edge performs the access:
  - Error check: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS). The upper-bit check is against the full 30-bit word address; there is no wrap or alias.
  - Read, no error: resp_rdata = mem[addr[AW+1:2]] and resp_err=0.
  - Write, no error: mem[idx] = wdata and resp_rdata=0.
  - Any error: no write occurs, resp_rdata=0 and resp_err=1.
- RESP lasts exactly one cycle with resp_valid=1, then the FSM goes to IDLE. On that edge resp_valid, resp_rdata and resp_err return to 0.
- Latency: resp_valid is high in the cycle starting LATENCY+1 edges after the accepting edge.
- Throughput: one request per LATENCY+2 cycles. A new request cannot be accepted in the RESP cycle.
- req_valid while req_ready=0 is ignored, not queued. Input changes after acceptance have no effect.
- A read following a write to the same word returns the new data.
- Reset mid-operation (WAIT or RESP): the transaction is aborted. If the write edge has not yet occurred, no write happens. No response is issued.
- Simultaneous events:
  - rst low overrides everything.
  - req_valid high in the last IDLE cycle before a reset edge is not accepted.

Decomposition:
- Shared package core_mem_pkg holds:
  - State encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - WORD_BYTES=4.
  - The misalignment mask 2'b11.
- One sub-module, mem_word_array: single-port, synchronous write, registered read, DEPTH_WORDS x 32, no reset.
- The top level contains the FSM, wait counter, request capture and error check.

Test Plan:
- LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10. Each response appears 3 cycles after accept with resp_err=0; the read returns 0xDEADBEEF.
- LATENCY=0: back-to-back reads with req_valid held high. Acceptances occur every 2 cycles, and req_ready=0 during every RESP cycle.
- Misaligned write to 0x13 with data 0x12345678 gives resp_err=1 and resp_rdata=0. A following read of 0x10 returns its old value, unchanged.
- DEPTH_WORDS=256: read 0x400 gives resp_err=1. Read 0x3FC gives resp_err=0 and returns the last word.
- LATENCY=3: assert rst=0 two cycles after accepting a write of 0xA5A5A5A5 to 0x20. No resp_valid appears, the following read of 0x20 returns the prior value, and req_ready=0 throughout reset.
- LATENCY=15: the counter boundary gives resp_valid exactly 16 cycles after accept.
